// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between the instruction-fetch requester (IF) and the
// load/store requester (D). Only one transaction is outstanding at a time. When
// both requesters are active, the one that did not own the previous transaction
// wins. D requests are checked for misalignment. Transactions that get no
// response within TIMEOUT_CYCLES complete with an error.
//
// Ports
//   clk_i, reset_i           clock, asynchronous active-high reset
//   if_req_i / if_addr_i     fetch request (always a word read)
//   if_gnt_o                 one-cycle capture pulse for the fetch request
//   if_rvalid_o/rdata/err    fetch completion, data and error flag
//   d_req_i/we/addr/wdata/size  load/store request
//   d_gnt_o                  one-cycle capture pulse for the data request
//   d_rvalid_o/rdata/err     data completion (loads and stores), data, error
//   m_req/we/addr/wdata/size registered memory request
//   m_gnt_i, m_rvalid_i, m_rdata_i  memory accept, response and read data
//
// The grant pulses and completions are combinational. All m_* request outputs
// come straight from flops.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        reset_i,
   // fetch requester
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   // load/store requester
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   input  logic [1:0]  d_size_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [31:0] d_rdata_o,
   output logic        d_err_o,
   // memory port
   output logic        m_req_o,
   output logic        m_we_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_wdata_o,
   output logic [1:0]  m_size_o,
   input  logic        m_gnt_i,
   input  logic        m_rvalid_i,
   input  logic [31:0] m_rdata_i
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   // r_owner holds the owner of the current transaction; it keeps that value
   // after completion, so it also serves as the last owner for arbitration.
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // Size 3 is illegal. Halfwords need an even address and words need a
   // 4-byte aligned address.
   function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = addr_lo[0];
         2'd2:    bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_owner;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  w_cnt_inc;
   logic           w_timeout;
   logic           w_d_bad;
   logic           w_grant_if;
   logic           w_grant_d;
   logic           w_done;
   logic           w_err;

   logic           r_m_req;
   logic           r_m_we;
   logic [31:0]    r_m_addr;
   logic [31:0]    r_m_wdata;
   logic [1:0]     r_m_size;

   assign w_d_bad   = f_misaligned(d_size_i, d_addr_i[1:0]);
   assign w_cnt_inc = r_cnt + CW'(1);
   // The timeout fires in the cycle whose increment would reach the limit,
   // i.e. on the TIMEOUT_CYCLES-th cycle after capture.
   assign w_timeout = ((r_state == ST_REQ) || (r_state == ST_RESP)) &&
                      (w_cnt_inc == CW'(TIMEOUT_CYCLES));

   // Arbitration, next-state and completion decode
   always_comb begin
      w_state_nxt = r_state;
      w_grant_if  = 1'b0;
      w_grant_d   = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Grants are suppressed while reset is held so every output is 0.
            if (reset_i) begin
               w_grant_if = 1'b0;
               w_grant_d  = 1'b0;
            end else if (if_req_i && d_req_i) begin
               if (r_owner == OWN_D) begin
                  w_grant_if = 1'b1;
               end else begin
                  w_grant_d = 1'b1;
               end
            end else if (if_req_i) begin
               w_grant_if = 1'b1;
            end else if (d_req_i) begin
               w_grant_d = 1'b1;
            end else begin
               w_grant_if = 1'b0;
               w_grant_d  = 1'b0;
            end

            if (w_grant_if) begin
               w_state_nxt = ST_REQ;
            end else if (w_grant_d) begin
               w_state_nxt = w_d_bad ? ST_ERR : ST_REQ;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (w_timeout) begin
               w_done      = 1'b1;
               w_err       = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (m_gnt_i) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_RESP: begin
            // The timeout takes precedence over a response in the same cycle.
            if (w_timeout) begin
               w_done      = 1'b1;
               w_err       = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (m_rvalid_i) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_ERR: begin
            w_done      = 1'b1;
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Owner, timeout counter and registered memory request fields
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_owner   <= OWN_D;
         r_cnt     <= '0;
         r_m_req   <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= 32'h0000_0000;
         r_m_wdata <= 32'h0000_0000;
         r_m_size  <= 2'd0;
      end else if (w_grant_if) begin
         r_owner   <= OWN_IF;
         r_cnt     <= '0;
         r_m_req   <= 1'b1;
         r_m_we    <= 1'b0;
         r_m_addr  <= if_addr_i;
         r_m_wdata <= 32'h0000_0000;
         r_m_size  <= 2'd2;
      end else if (w_grant_d) begin
         r_owner   <= OWN_D;
         r_cnt     <= '0;
         // A misaligned request is captured but never reaches the memory.
         r_m_req   <= ~w_d_bad;
         r_m_we    <= d_we_i;
         r_m_addr  <= d_addr_i;
         r_m_wdata <= d_wdata_i;
         r_m_size  <= d_size_i;
      end else begin
         if ((r_state == ST_REQ) || (r_state == ST_RESP)) begin
            r_cnt <= w_cnt_inc;
         end
         if ((r_state == ST_REQ) && (m_gnt_i || w_timeout)) begin
            r_m_req <= 1'b0;
         end
      end
   end

   assign if_gnt_o    = w_grant_if;
   assign d_gnt_o     = w_grant_d;

   assign if_rvalid_o = w_done & (r_owner == OWN_IF);
   assign if_err_o    = w_done & w_err & (r_owner == OWN_IF);
   assign if_rdata_o  = (if_rvalid_o && !w_err) ? m_rdata_i : 32'h0000_0000;

   assign d_rvalid_o  = w_done & (r_owner == OWN_D);
   assign d_err_o     = w_done & w_err & (r_owner == OWN_D);
   assign d_rdata_o   = (d_rvalid_o && !w_err) ? m_rdata_i : 32'h0000_0000;

   assign m_req_o     = r_m_req;
   assign m_we_o      = r_m_we;
   assign m_addr_o    = r_m_addr;
   assign m_wdata_o   = r_m_wdata;
   assign m_size_o    = r_m_size;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (TIMEOUT_CYCLES = 8). Inputs change on the
// falling clock edge and outputs are checked 1 time unit later. Expected
// completions are queued when a request is driven and popped when the DUT
// raises an rvalid.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        if_err_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [1:0]  d_size_i;
   logic        d_gnt_o;
   logic        d_rvalid_o;
   logic [31:0] d_rdata_o;
   logic        d_err_o;
   logic        m_req_o;
   logic        m_we_o;
   logic [31:0] m_addr_o;
   logic [31:0] m_wdata_o;
   logic [1:0]  m_size_o;
   logic        m_gnt_i;
   logic        m_rvalid_i;
   logic [31:0] m_rdata_i;

   typedef struct {
      string       tag;
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
      logic        chk_data;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_gnt_o   (if_gnt_o),
      .if_rvalid_o(if_rvalid_o),
      .if_rdata_o (if_rdata_o),
      .if_err_o   (if_err_o),
      .d_req_i    (d_req_i),
      .d_we_i     (d_we_i),
      .d_addr_i   (d_addr_i),
      .d_wdata_i  (d_wdata_i),
      .d_size_i   (d_size_i),
      .d_gnt_o    (d_gnt_o),
      .d_rvalid_o (d_rvalid_o),
      .d_rdata_o  (d_rdata_o),
      .d_err_o    (d_err_o),
      .m_req_o    (m_req_o),
      .m_we_o     (m_we_o),
      .m_addr_o   (m_addr_o),
      .m_wdata_o  (m_wdata_o),
      .m_size_o   (m_size_o),
      .m_gnt_i    (m_gnt_i),
      .m_rvalid_i (m_rvalid_i),
      .m_rdata_i  (m_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls
   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_cpl(input string tag, input logic is_d, input logic [31:0] rdata,
                             input logic err, input logic chk_data);
      exp_t e;
      e.tag      = tag;
      e.is_d     = is_d;
      e.rdata    = rdata;
      e.err      = err;
      e.chk_data = chk_data;
      sb.push_back(e);
   endtask

   // Settle after driving, then score any completion against the queue
   task automatic sample();
      exp_t e;
      #1;
      if (if_rvalid_o === 1'b1 || d_rvalid_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rvalid", 32'({if_rvalid_o, d_rvalid_o}), 32'h0);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_owner"}, 32'({if_rvalid_o, d_rvalid_o}), e.is_d ? 32'h1 : 32'h2);
            chk({e.tag, "_err"}, 32'(e.is_d ? d_err_o : if_err_o), 32'(e.err));
            if (e.chk_data) begin
               chk({e.tag, "_rdata"}, e.is_d ? d_rdata_o : if_rdata_o, e.rdata);
            end
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, 32'({if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, if_err_o, d_err_o,
                              m_req_o, m_we_o}), 32'h0);
      chk({tag, "_maddr"}, m_addr_o, 32'h0);
      chk({tag, "_rdata"}, if_rdata_o | d_rdata_o, 32'h0);
   endtask

   logic [1:0]  mis_size [3];
   logic [31:0] mis_addr [3];

   initial begin
      mis_size = '{2'd2, 2'd1, 2'd3};
      mis_addr = '{32'h0000_0102, 32'h0000_0101, 32'h0000_0100};

      rst = 1'b1;
      if_req_i = 1'b0; if_addr_i = 32'h0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h0; d_wdata_i = 32'h0; d_size_i = 2'd0;
      m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = 32'h0;

      // ---- reset state: requests held, nothing may come out ----
      @(negedge clk);
      if_req_i = 1'b1; d_req_i = 1'b1;
      sample();
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0; if_req_i = 1'b0; d_req_i = 1'b0;
      sample();

      // ---- single fetch ----
      @(negedge clk);
      if_req_i = 1'b1; if_addr_i = 32'h0001_0000;
      sample();
      chk("f_gnt", 32'({if_gnt_o, d_gnt_o}), 32'h2);
      expect_cpl("fetch", 1'b0, 32'h0000_0013, 1'b0, 1'b1);
      @(negedge clk);
      if_req_i = 1'b0;
      sample();
      chk("f_mreq1", 32'({m_req_o, m_we_o, if_gnt_o}), 32'h4);
      chk("f_maddr", m_addr_o, 32'h0001_0000);
      chk("f_msize", 32'(m_size_o), 32'h2);
      chk("f_mwdata", m_wdata_o, 32'h0);
      @(negedge clk);
      m_gnt_i = 1'b1;
      sample();
      chk("f_mreq2", 32'(m_req_o), 32'h1);
      @(negedge clk);
      m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0013;
      sample();
      chk("f_rvalid", 32'({if_rvalid_o, m_req_o}), 32'h2);
      @(negedge clk);
      m_rvalid_i = 1'b0;
      sample();
      chk("f_drained", 32'(sb.size()), 32'h0);

      // ---- both requesting from reset: grants alternate IF, D, IF, D ----
      @(negedge clk);
      rst = 1'b1;
      sample();
      @(negedge clk);
      rst = 1'b0;
      if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0200; d_size_i = 2'd2;
      for (int k = 0; k < 4; k++) begin
         m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
         sample();
         chk($sformatf("alt%0d_gnt", k), 32'({if_gnt_o, d_gnt_o}),
             (k % 2 == 0) ? 32'h2 : 32'h1);
         expect_cpl($sformatf("alt%0d", k), (k % 2 != 0), 32'hA000_0000 + 32'(k), 1'b0, 1'b1);
         @(negedge clk);
         sample();
         chk($sformatf("alt%0d_idle", k), 32'({if_gnt_o, d_gnt_o, m_req_o}), 32'h1);
         chk($sformatf("alt%0d_maddr", k), m_addr_o,
             (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_0200);
         @(negedge clk);
         m_gnt_i = 1'b1;
         sample();
         @(negedge clk);
         m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hA000_0000 + 32'(k);
         sample();
         chk($sformatf("alt%0d_done", k), 32'({if_rvalid_o, d_rvalid_o}),
             (k % 2 == 0) ? 32'h2 : 32'h1);
         @(negedge clk);
      end
      if_req_i = 1'b0; d_req_i = 1'b0; m_rvalid_i = 1'b0;
      sample();
      chk("alt_drained", 32'(sb.size()), 32'h0);

      // ---- aligned word store ----
      @(negedge clk);
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_0100;
      d_wdata_i = 32'hDEAD_BEEF; d_size_i = 2'd2;
      sample();
      chk("st_gnt", 32'({if_gnt_o, d_gnt_o}), 32'h1);
      expect_cpl("store", 1'b1, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      d_req_i = 1'b0;
      sample();
      chk("st_mctl", 32'({m_req_o, m_we_o, m_size_o}), 32'hE);
      chk("st_mwdata", m_wdata_o, 32'hDEAD_BEEF);
      chk("st_maddr", m_addr_o, 32'h0000_0100);
      @(negedge clk);
      m_gnt_i = 1'b1;
      sample();
      @(negedge clk);
      m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h5555_5555;
      sample();
      chk("st_done", 32'({d_rvalid_o, d_err_o}), 32'h2);
      @(negedge clk);
      m_rvalid_i = 1'b0; d_we_i = 1'b0;
      sample();

      // ---- misaligned / illegal data requests ----
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         d_req_i = 1'b1; d_addr_i = mis_addr[k]; d_size_i = mis_size[k];
         sample();
         chk($sformatf("mis%0d_gnt", k), 32'(d_gnt_o), 32'h1);
         expect_cpl($sformatf("mis%0d", k), 1'b1, 32'h0, 1'b1, 1'b0);
         @(negedge clk);
         d_req_i = 1'b0;
         sample();
         chk($sformatf("mis%0d_cpl", k), 32'({d_rvalid_o, d_err_o, m_req_o}), 32'h6);
         @(negedge clk);
         sample();
         chk($sformatf("mis%0d_after", k), 32'({d_rvalid_o, m_req_o}), 32'h0);
      end

      // ---- memory never grants: timeout after 8 cycles ----
      @(negedge clk);
      if_req_i = 1'b1; if_addr_i = 32'h0000_0004;
      sample();
      chk("to_gnt", 32'(if_gnt_o), 32'h1);
      expect_cpl("timeout", 1'b0, 32'h0, 1'b1, 1'b0);
      for (int c = 1; c < 8; c++) begin
         @(negedge clk);
         if_req_i = 1'b0;
         sample();
         chk($sformatf("to_wait%0d", c), 32'({m_req_o, if_rvalid_o}), 32'h2);
      end
      @(negedge clk);
      sample();
      chk("to_fire", 32'({if_rvalid_o, if_err_o}), 32'h3);
      @(negedge clk);
      m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0BAD;
      sample();
      chk("to_late", 32'({m_req_o, if_rvalid_o, d_rvalid_o}), 32'h0);
      @(negedge clk);
      m_rvalid_i = 1'b0;
      sample();

      // ---- reset while waiting for the response ----
      @(negedge clk);
      if_req_i = 1'b1; if_addr_i = 32'h0000_0008;
      sample();
      chk("rr_gnt", 32'(if_gnt_o), 32'h1);
      @(negedge clk);
      if_req_i = 1'b0;
      sample();
      @(negedge clk);
      m_gnt_i = 1'b1;
      sample();
      @(negedge clk);
      m_gnt_i = 1'b0; rst = 1'b1;
      if_req_i = 1'b1; if_addr_i = 32'h0000_000C;
      sample();
      chk_all_zero("rr_reset");
      @(negedge clk);
      rst = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0077;
      sample();
      chk("rr_regnt", 32'({if_gnt_o, if_rvalid_o}), 32'h2);
      expect_cpl("rr_fetch", 1'b0, 32'h0000_0099, 1'b0, 1'b1);
      @(negedge clk);
      if_req_i = 1'b0; m_rvalid_i = 1'b0;
      sample();
      chk("rr_maddr", m_addr_o, 32'h0000_000C);
      @(negedge clk);
      m_gnt_i = 1'b1;
      sample();
      @(negedge clk);
      m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0099;
      sample();
      chk("rr_done", 32'(if_rvalid_o), 32'h1);
      @(negedge clk);
      m_rvalid_i = 1'b0;
      sample();

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
